gray_steer: RTL and testbench

GRAY_STEER -- requirements
Module: gray_steer

---
 rtl/gray_steer.sv | 192 +++++++++++++++++++
 tb/tb_gray_steer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_steer.sv
// -----------------------------------------------------------------------------
// gray_steer
//
// Steers an external 16-state Gray-coded FSM to a requested target state. The
// block cannot read the FSM state directly. It keeps a shadow copy of the FSM
// index and advances it every clock edge with the FSM's own next-state rule
// and the command driven that cycle. In STEER it issues route commands until
// the shadow reaches the target. It gives up with an error once HOP_LIMIT hops
// have been taken without a match.
//
// Parameters
//   HOP_LIMIT   maximum hops per request before abort (1..31)
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   steering request present
//   req_target  target state index 0..15 (sampled only on the accept edge)
//   req_ready   request accepted on an edge where req_valid & req_ready
//   obs_out     one-hot output observed from the Gray FSM
//   cmd         command driven to the Gray FSM every cycle
//   busy        high while steering
//   done        one-cycle pulse when a request finishes (normally or aborted)
//   done_hops   hops taken by the finished request, valid while done=1
//   err         sticky error flag (held until reset)
//
// Build option
//   GRAY_STEER_CHECK_EN  when defined, every cycle obs_out is compared with
//                        1 << gray(shadow)[2:0]. A mismatch raises err and
//                        parks the block in ERR. When it is not defined,
//                        obs_out is ignored and only HOP_LIMIT can raise err.
// -----------------------------------------------------------------------------
module gray_steer #(
  parameter int unsigned HOP_LIMIT = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_target,
  output logic       req_ready,
  input  logic [7:0] obs_out,
  output logic [3:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [4:0] done_hops,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEER = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [4:0] HOP_MAX = 5'(HOP_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] target_q, target_d;
  logic [4:0] hop_q, hop_d;
  logic       obs_err;

  // Next-state rule of the external Gray FSM, indexed by its state number.
  function automatic logic [3:0] fsm_next(input logic [3:0] s, input logic [3:0] c);
    logic [3:0] n;
    n = 4'd0;
    case (s)
      4'd0:    n = c[0] ? 4'd1 : 4'd8;
      4'd1:    n = (c[1:0] == 2'b11) ? 4'd2 : 4'd0;
      4'd2:    n = 4'd3;
      4'd3:    n = c[2] ? 4'd4 : 4'd1;
      4'd4:    n = c[3] ? 4'd5 : 4'd12;
      4'd5:    n = 4'd6;
      4'd6:    n = (c != 4'd0) ? 4'd7 : 4'd4;
      4'd7:    n = 4'd0;
      4'd8:    n = (c[3:2] == 2'b01) ? 4'd9 : 4'd15;
      4'd9:    n = 4'd10;
      4'd10:   n = c[1] ? 4'd11 : 4'd9;
      4'd11:   n = 4'd12;
      4'd12:   n = (c[0] ^ c[1]) ? 4'd13 : 4'd14;
      4'd13:   n = 4'd0;
      4'd14:   n = 4'd15;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Command that moves the FSM one hop closer to target t from state s.
  // A zero command lets the FSM take its default branch. Where the default
  // branch already leads toward t, the route is zero.
  function automatic logic [3:0] route(input logic [3:0] s, input logic [3:0] t);
    logic [3:0] c;
    c = 4'b0000;
    case (s)
      4'd0:    if (t inside {[4'd1:4'd7]})                c = 4'b0001;
      4'd1:    if (t inside {[4'd2:4'd7]})                c = 4'b0011;
      4'd3:    if (t inside {[4'd4:4'd7], [4'd12:4'd14]}) c = 4'b0100;
      4'd4:    if (t inside {[4'd5:4'd7]})                c = 4'b1000;
      4'd6:    if (!(t inside {4'd4, 4'd5, [4'd12:4'd14]})) c = 4'b0001;
      4'd8:    if (t inside {[4'd9:4'd14]})               c = 4'b0100;
      4'd10:   if (t != 4'd9)                             c = 4'b0010;
      4'd12:   if (t == 4'd13)                            c = 4'b0001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

`ifdef GRAY_STEER_CHECK_EN
  // Only the low three Gray bits select the one-hot observation bit.
  logic [2:0] gray_lo;
  logic [7:0] obs_exp;
  assign gray_lo = shadow_q[2:0] ^ shadow_q[3:1];
  assign obs_exp = 8'd1 << gray_lo;
  assign obs_err = (obs_out != obs_exp);
`else
  logic unused_obs;
  assign unused_obs = ^obs_out;
  assign obs_err    = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned; an unassigned path would infer a latch.
    state_d   = state_q;
    target_d  = target_q;
    hop_d     = hop_q;
    req_ready = 1'b0;
    cmd       = 4'b0000;
    busy      = 1'b0;
    done      = 1'b0;
    done_hops = 5'd0;
    err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (obs_err) begin
          err     = 1'b1;
          state_d = ST_ERR;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            target_d = req_target;
            hop_d    = 5'd0;
            state_d  = ST_STEER;
          end
        end
      end
      ST_STEER: begin
        busy = 1'b1;
        if (obs_err || (shadow_q != target_q && hop_q == HOP_MAX)) begin
          done      = 1'b1;
          done_hops = hop_q;
          err       = 1'b1;
          state_d   = ST_ERR;
        end else if (shadow_q == target_q) begin
          done      = 1'b1;
          done_hops = hop_q;
          state_d   = ST_IDLE;
        end else begin
          cmd   = route(shadow_q, target_q);
          hop_d = hop_q + 5'd1;
        end
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The shadow follows the FSM in every state, including IDLE and ERR.
    shadow_d = fsm_next(shadow_q, cmd);
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= 4'd0;
      target_q <= 4'd0;
      hop_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      hop_q    <= hop_d;
    end
  end

endmodule

// File: tb/tb_gray_steer.sv
// -----------------------------------------------------------------------------
// tb_gray_steer
//
// Two gray_steer instances share the request inputs. One uses the default
// HOP_LIMIT of 31 and the other uses HOP_LIMIT of 4. A reference model tracks
// both instances from the block's rules: the FSM transition table, the route
// table and the request protocol. The model drives obs_out as the external FSM
// would present it. Every cycle it checks each instance's outputs. Directed
// steps cover the documented scenarios, then random requests follow.
// -----------------------------------------------------------------------------
module tb_gray_steer;

  localparam int LIM0 = 31;
  localparam int LIM1 = 4;
`ifdef GRAY_STEER_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_target;
  logic [7:0] obs0, obs1;

  logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
  logic [3:0] cmd0, cmd1;
  logic [4:0] hops0, hops1;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: 0 idle, 1 steering, 2 error.
  int         m_st[2];
  logic [3:0] m_sh[2];
  logic [3:0] m_tg[2];
  int         m_hop[2];
  logic [4:0] cap_hops[2];
  logic       cap_err[2];

  typedef struct {
    logic       rdy;
    logic [3:0] cmd;
    logic       busy;
    logic       done;
    logic [4:0] hops;
    logic       err;
  } dut_obs_t;

  always #5 clk = ~clk;

  gray_steer #(.HOP_LIMIT(LIM0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_target(req_target),
    .req_ready(rdy0), .obs_out(obs0), .cmd(cmd0), .busy(busy0), .done(done0),
    .done_hops(hops0), .err(err0)
  );

  gray_steer #(.HOP_LIMIT(LIM1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_target(req_target),
    .req_ready(rdy1), .obs_out(obs1), .cmd(cmd1), .busy(busy1), .done(done1),
    .done_hops(hops1), .err(err1)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic dut_obs_t dut_out(input int i);
    dut_obs_t d;
    if (i == 0) begin
      d.rdy = rdy0; d.cmd = cmd0; d.busy = busy0; d.done = done0; d.hops = hops0; d.err = err0;
    end else begin
      d.rdy = rdy1; d.cmd = cmd1; d.busy = busy1; d.done = done1; d.hops = hops1; d.err = err1;
    end
    return d;
  endfunction

  // External FSM transition table.
  function automatic logic [3:0] nxt(input logic [3:0] s, input logic [3:0] c);
    case (s)
      4'd0:    return c[0] ? 4'd1 : 4'd8;
      4'd1:    return (c[1:0] == 2'b11) ? 4'd2 : 4'd0;
      4'd3:    return c[2] ? 4'd4 : 4'd1;
      4'd4:    return c[3] ? 4'd5 : 4'd12;
      4'd6:    return (c != 4'd0) ? 4'd7 : 4'd4;
      4'd8:    return (c[3:2] == 2'b01) ? 4'd9 : 4'd15;
      4'd10:   return c[1] ? 4'd11 : 4'd9;
      4'd12:   return (c[0] ^ c[1]) ? 4'd13 : 4'd14;
      4'd7, 4'd13, 4'd15: return 4'd0;
      default: return s + 4'd1;   // 2, 5, 9, 11, 14 always step to s+1
    endcase
  endfunction

  // Route table.
  function automatic logic [3:0] rte(input logic [3:0] s, input logic [3:0] t);
    int ti;
    ti = int'(t);
    case (s)
      4'd0:  return (ti >= 1 && ti <= 7) ? 4'b0001 : 4'b0000;
      4'd1:  return (ti >= 2 && ti <= 7) ? 4'b0011 : 4'b0000;
      4'd3:  return ((ti >= 4 && ti <= 7) || (ti >= 12 && ti <= 14)) ? 4'b0100 : 4'b0000;
      4'd4:  return (ti >= 5 && ti <= 7) ? 4'b1000 : 4'b0000;
      4'd6:  return (ti == 4 || ti == 5 || (ti >= 12 && ti <= 14)) ? 4'b0000 : 4'b0001;
      4'd8:  return (ti >= 9 && ti <= 14) ? 4'b0100 : 4'b0000;
      4'd10: return (ti == 9) ? 4'b0000 : 4'b0010;
      4'd12: return (ti == 13) ? 4'b0001 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  // Observation the FSM presents in state s: one-hot of the low Gray bits.
  function automatic logic [7:0] obs_of(input logic [3:0] s);
    logic [3:0] g;
    g = s ^ {1'b0, s[3:1]};
    return 8'd1 << g[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle. Entered just after a falling edge and left at the next one.
  task automatic step(input logic v, input logic [3:0] t, input logic bad);
    req_valid  = v;
    req_target = t;
    obs0 = bad ? 8'h80 : obs_of(m_sh[0]);
    obs1 = bad ? 8'h80 : obs_of(m_sh[1]);
    #1;
    for (int i = 0; i < 2; i++) begin
      dut_obs_t   d;
      logic       e_rdy, e_busy, e_done, e_err, mis;
      logic [3:0] e_cmd;
      logic [4:0] e_hops;
      int         lim;
      d      = dut_out(i);
      lim    = (i == 0) ? LIM0 : LIM1;
      e_rdy  = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_cmd  = 4'b0000; e_hops = 5'd0;
      mis    = CHK_EN && (((i == 0) ? obs0 : obs1) != obs_of(m_sh[i]));
      if (m_st[i] == 0) begin
        if (mis) begin
          e_err = 1'b1; m_st[i] = 2;
        end else begin
          e_rdy = 1'b1;
          if (v) begin
            m_tg[i] = t; m_hop[i] = 0; m_st[i] = 1;
          end
        end
      end else if (m_st[i] == 1) begin
        e_busy = 1'b1;
        if (mis || (m_sh[i] != m_tg[i] && m_hop[i] == lim)) begin
          e_done = 1'b1; e_err = 1'b1; e_hops = 5'(m_hop[i]); m_st[i] = 2;
        end else if (m_sh[i] == m_tg[i]) begin
          e_done = 1'b1; e_hops = 5'(m_hop[i]); m_st[i] = 0;
        end else begin
          e_cmd = rte(m_sh[i], m_tg[i]); m_hop[i]++;
        end
      end else begin
        e_err = 1'b1;
      end
      check($sformatf("u%0d req_ready", i), 32'(d.rdy),  32'(e_rdy));
      check($sformatf("u%0d cmd", i),       32'(d.cmd),  32'(e_cmd));
      check($sformatf("u%0d busy", i),      32'(d.busy), 32'(e_busy));
      check($sformatf("u%0d done", i),      32'(d.done), 32'(e_done));
      check($sformatf("u%0d done_hops", i), 32'(d.hops), 32'(e_hops));
      check($sformatf("u%0d err", i),       32'(d.err),  32'(e_err));
      if (d.done === 1'b1) begin
        cap_hops[i] = d.hops;
        cap_err[i]  = d.err;
      end
      m_sh[i] = nxt(m_sh[i], e_cmd);
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the cleared outputs at once, and releases
  // reset on the following falling edge.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    obs0      = obs_of(4'd0);
    obs1      = obs_of(4'd0);
    #1;
    for (int i = 0; i < 2; i++) begin
      dut_obs_t d;
      d = dut_out(i);
      check($sformatf("rst u%0d req_ready", i), 32'(d.rdy),  32'd1);
      check($sformatf("rst u%0d cmd", i),       32'(d.cmd),  32'd0);
      check($sformatf("rst u%0d busy", i),      32'(d.busy), 32'd0);
      check($sformatf("rst u%0d done", i),      32'(d.done), 32'd0);
      check($sformatf("rst u%0d done_hops", i), 32'(d.hops), 32'd0);
      check($sformatf("rst u%0d err", i),       32'(d.err),  32'd0);
      m_st[i] = 0; m_sh[i] = 4'd0; m_tg[i] = 4'd0; m_hop[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents a request for one cycle, then waits for instance 0 to finish.
  task automatic request(input logic [3:0] t);
    int n;
    cap_hops[0] = 'x; cap_hops[1] = 'x;
    cap_err[0]  = 1'bx; cap_err[1] = 1'bx;
    step(1'b1, t, 1'b0);
    n = 0;
    while (m_st[0] == 1 && n < 64) begin
      step(1'b0, 4'($urandom), 1'b0);   // req_target noise must be ignored
      n++;
    end
    check("request cycle bound", 32'(n < 64), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_target = 4'd0;
    obs0       = obs_of(4'd0);
    obs1       = obs_of(4'd0);
    @(negedge clk);

    // Target 8 from shadow 0: a single STEER cycle, zero hops.
    do_reset();
    request(4'd8);
    check("t8 u0 done_hops", 32'(cap_hops[0]), 32'd0);
    check("t8 u1 done_hops", 32'(cap_hops[1]), 32'd0);

    // Target 1 from shadow 0: path 8, 15, 0, 1, three hops.
    do_reset();
    request(4'd1);
    check("t1 u0 done_hops", 32'(cap_hops[0]), 32'd3);
    check("t1 u1 done_hops", 32'(cap_hops[1]), 32'd3);

    // Target 7: nine hops with the default limit. Limit 4 aborts after 4 hops.
    do_reset();
    request(4'd7);
    check("t7 u0 done_hops", 32'(cap_hops[0]), 32'd9);
    check("t7 u0 done err",  32'(cap_err[0]),  32'd0);
    check("t7 u1 done_hops", 32'(cap_hops[1]), 32'd4);
    check("t7 u1 done err",  32'(cap_err[1]),  32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 4'd3, 1'b0);
    check("limit u1 ready stuck low", 32'(rdy1), 32'd0);
    check("limit u1 err sticky",      32'(err1), 32'd1);

    // Wrong observation while shadow is 0. It takes effect only when checking
    // is built in.
    do_reset();
    step(1'b0, 4'd0, 1'b1);
    check("bad obs u0 err", 32'(err0), 32'(CHK_EN));
    step(1'b0, 4'd0, 1'b0);

    // Reset in the middle of a request, then a fresh request after release.
    do_reset();
    step(1'b1, 4'd7, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'd2, 1'b0);
    check("mid-steer u0 busy", 32'(busy0), 32'd1);
    do_reset();
    request(4'd5);
    check("after reset u0 done_hops", 32'(cap_hops[0]), 32'd7);

    // Random requests with random idle gaps.
    do_reset();
    for (int r = 0; r < 30; r++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step(1'b0, 4'($urandom), 1'b0);
      request(4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
